// File: rtl/a2d_seq_pkg.sv
// Shared types and helpers for the ADC128S sweep sequencer.
package a2d_seq_pkg;

    localparam int CH_W  = 3;
    localparam int RES_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        TX1,
        W1,
        TX2,
        W2,
        FIN
    } state_t;

    function automatic logic [15:0] mk_cmd(input logic [CH_W-1:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

    // Scans from the top down so the last hit is the lowest set bit; returns 0 for an empty mask.
    function automatic logic [CH_W-1:0] first_set(input logic [7:0] mask);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/a2d_sweep_ctrl_timer.sv
// Free-running sweep period counter; held at zero while disabled.
module sweep_timer #(
    parameter int PERIOD_CLKS = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic expiry_o
);

    localparam int CNT_W = (PERIOD_CLKS > 2) ? $clog2(PERIOD_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CLKS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!en_i) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expiry_o = en_i && (count_q == LAST);

endmodule

// File: rtl/a2d_sweep_ctrl.sv
// Sweep sequencer: drives the SPI master through select/convert pairs per enabled
// ADC channel and keeps the latest 12-bit result for each channel.
module a2d_sweep_ctrl
    import a2d_seq_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int PERIOD_CLKS = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               trig,
    input  logic [7:0]         ch_mask,
    output logic               wrt,
    output logic [15:0]        cmd,
    input  logic               done,
    input  logic [15:0]        rd_data,
    input  logic [CH_W-1:0]    rd_ch,
    output logic [RES_W-1:0]   rd_res,
    output logic [7:0]         res_vld,
    output logic               busy,
    output logic               sweep_done,
    output logic               overrun
);

    localparam logic [7:0] CH_MASK_ALL = 8'((1 << NUM_CH) - 1);

    state_t            state_q, state_d;
    logic [7:0]        mask_q, mask_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [15:0]       cmd_q, cmd_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic [RES_W-1:0]  res_q [8];
    logic [7:0]        res_vld_q;
    logic              res_we;
    logic              expiry;
    logic              start;
    logic              unused_rd_hi;

    sweep_timer #(
        .PERIOD_CLKS(PERIOD_CLKS)
    ) u_timer (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .expiry_o(expiry)
    );

    assign start = trig | pending_q | expiry;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ch_d       = ch_q;
        cmd_d      = cmd_q;
        res_we     = 1'b0;
        wrt        = 1'b0;
        busy       = 1'b0;
        sweep_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEL;
                    mask_d  = ch_mask & CH_MASK_ALL;
                end
            end
            SEL: begin
                busy = 1'b1;
                if (mask_q == 8'h00) begin
                    state_d = FIN;
                end else begin
                    ch_d    = first_set(mask_q);
                    cmd_d   = mk_cmd(ch_d);
                    mask_d  = mask_q & (mask_q - 8'h01);
                    state_d = TX1;
                end
            end
            TX1: begin
                busy    = 1'b1;
                wrt     = 1'b1;
                state_d = W1;
            end
            W1: begin
                busy = 1'b1;
                if (done) state_d = TX2;
            end
            TX2: begin
                busy    = 1'b1;
                wrt     = 1'b1;
                state_d = W2;
            end
            W2: begin
                busy = 1'b1;
                if (done) begin
                    res_we  = 1'b1;
                    state_d = (mask_q != 8'h00) ? SEL : FIN;
                end
            end
            FIN: begin
                sweep_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Any request outside IDLE (FIN included) is remembered once; a further expiry is the overrun.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (state_q == IDLE) begin
            pending_d = 1'b0;
        end else begin
            if (expiry && pending_q) overrun_d = 1'b1;
            if ((trig || expiry) && !pending_q) pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            ch_q      <= '0;
            cmd_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            res_vld_q <= '0;
            for (int i = 0; i < 8; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            ch_q      <= ch_d;
            cmd_q     <= cmd_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            if (res_we) begin
                res_q[ch_q]     <= rd_data[RES_W-1:0];
                res_vld_q[ch_q] <= 1'b1;
            end
        end
    end

    assign cmd          = cmd_q;
    assign overrun      = overrun_q;
    assign res_vld      = res_vld_q;
    assign rd_res       = res_q[rd_ch];
    assign unused_rd_hi = ^rd_data[15:RES_W];

endmodule

// File: tb/tb_a2d_sweep_ctrl.sv
// Randomized bench for a2d_sweep_ctrl with a behavioural SPI responder and a
// transaction-level model of sweeps, request pending/overrun and the result file.
module tb_a2d_sweep_ctrl;

    localparam int NUM_CH = 8;
    localparam int PERIOD = 200;

    logic        clk = 1'b0;
    logic        rst_n, en, trig, done;
    logic [7:0]  chMask;
    logic        wrt;
    logic [15:0] cmd, rdData;
    logic [2:0]  rdCh;
    logic [11:0] rdRes;
    logic [7:0]  resVld;
    logic        busy, sweepDone, overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    a2d_sweep_ctrl #(
        .NUM_CH     (NUM_CH),
        .PERIOD_CLKS(PERIOD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .trig      (trig),
        .ch_mask   (chMask),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .rd_data   (rdData),
        .rd_ch     (rdCh),
        .rd_res    (rdRes),
        .res_vld   (resVld),
        .busy      (busy),
        .sweep_done(sweepDone),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // SPI master + ADC stand-in: clears done on wrt, raises it with fresh data after a random latency.
    int          latLo = 2;
    int          latHi = 6;
    int          waitCnt;
    int          txnCount;
    logic [2:0]  txnCh;
    logic        capArmed;
    logic [2:0]  capCh;
    logic [11:0] capVal;
    logic [15:0] respData;
    logic [11:0] resM [8];
    logic [7:0]  vldM;

    always @(posedge clk) begin
        if (!rst_n) begin
            done     <= 1'b0;
            rdData   <= '0;
            waitCnt  = 0;
            txnCount = 0;
            capArmed = 1'b0;
            vldM     = '0;
            for (int i = 0; i < 8; i++) resM[i] = '0;
        end else begin
            if (capArmed) begin
                resM[capCh] = capVal;
                vldM[capCh] = 1'b1;
                capArmed    = 1'b0;
            end
            if (wrt) begin
                done     <= 1'b0;
                waitCnt  = $urandom_range(latHi, latLo);
                txnCh    = cmd[13:11];
                txnCount++;
            end else if (waitCnt > 0) begin
                waitCnt--;
                if (waitCnt == 0) begin
                    respData = 16'($urandom);
                    rdData   <= respData;
                    done     <= 1'b1;
                    if (txnCount % 2 == 0) begin
                        capArmed = 1'b1;
                        capCh    = txnCh;
                        capVal   = respData[11:0];
                    end
                end
            end
        end
    end

    // Sweep-level model: expected command list per sweep, request pending/overrun, timer expiry.
    logic        live = 1'b0;
    logic        pendM, ovrM, prevBusy, prevWrt, expValid, expBusyNext, expiryM, inSweep;
    logic [7:0]  prevMask;
    logic [15:0] lastCmdM;
    int          enRun;
    int          sweeps = 0;
    logic [15:0] expQ [$];
    logic [15:0] wrtLog [$];
    int          startCycles [$];
    int          doneCycles [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            pendM       = 1'b0;
            ovrM        = 1'b0;
            enRun       = 0;
            expQ.delete();
            prevBusy    = 1'b0;
            prevWrt     = 1'b0;
            expValid    = 1'b1;
            expBusyNext = 1'b0;
            lastCmdM    = '0;
            prevMask    = chMask;
            live        = 1'b1;
        end else if (live) begin
            if (en) enRun++;
            else enRun = 0;
            expiryM = en && (enRun % PERIOD == 0);
            inSweep = busy || sweepDone;
            if (expValid) checkOutput("busy_start", busy, expBusyNext);
            checkOutput("overrun", overrun, ovrM);
            checkOutput("res_vld", resVld, vldM);
            checkOutput("rd_res", rdRes, resM[rdCh]);
            if (busy && !prevBusy) begin
                checkOutput("queue_empty_at_start", expQ.size(), 0);
                startCycles.push_back(cyc);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (prevMask[c]) begin
                        expQ.push_back({2'b00, 3'(c), 11'h000});
                        expQ.push_back({2'b00, 3'(c), 11'h000});
                    end
                end
            end
            if (wrt) begin
                checkOutput("wrt_single_cycle", prevWrt, 1'b0);
                wrtLog.push_back(cmd);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_wrt: got cmd %0h, expected no transaction", cmd);
                end else begin
                    lastCmdM = expQ.pop_front();
                end
            end
            checkOutput("cmd", cmd, lastCmdM);
            if (sweepDone) begin
                checkOutput("queue_empty_at_done", expQ.size(), 0);
                sweeps++;
                doneCycles.push_back(cyc);
            end
            expValid    = !inSweep || sweepDone;
            expBusyNext = !inSweep && (trig || expiryM || pendM);
            if (!inSweep) begin
                pendM = 1'b0;
            end else begin
                if (expiryM && pendM) ovrM = 1'b1;
                if ((trig || expiryM) && !pendM) pendM = 1'b1;
            end
            prevBusy = busy;
            prevWrt  = wrt;
            prevMask = chMask;
        end
    end

    logic randRd = 1'b1;
    initial forever begin
        @(posedge clk);
        #1;
        if (randRd) rdCh = 3'($urandom);
    end

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int trigCycle;
    task automatic pulseTrig();
        applyStimulus(1);
        trig      = 1'b1;
        trigCycle = cyc;
        applyStimulus(1);
        trig = 1'b0;
    endtask

    task automatic waitSweeps(input int target, input int budget, input string name);
        int n = 0;
        while (sweeps < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sweeps < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d sweeps, expected %0d", name, sweeps, target);
        end
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = (busy || sweepDone) ? 0 : quiet + 1;
        end
        if (quiet < 4) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_idle_timeout: got busy %0b, expected idle", name, busy);
        end
    endtask

    logic [15:0] t1Cmds [4] = '{16'h0000, 16'h0000, 16'h1000, 16'h1000};
    logic [15:0] t5Cmds [6] = '{16'h0000, 16'h0000, 16'h0800, 16'h0800, 16'h2000, 16'h2000};

    initial begin
        int base;
        int sb;
        int db;
        int n;
        rst_n  = 1'b0;
        en     = 1'b0;
        trig   = 1'b0;
        chMask = 8'h00;
        rdCh   = 3'd0;
        applyStimulus(3);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_wrt", wrt, 1'b0);
        checkOutput("reset_cmd", cmd, 16'h0000);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_sweep_done", sweepDone, 1'b0);
        checkOutput("reset_overrun", overrun, 1'b0);
        checkOutput("reset_res_vld", resVld, 8'h00);
        checkOutput("reset_rd_res", rdRes, 12'h000);

        // Single triggered sweep of channels 0 and 2.
        wrtLog.delete();
        base   = sweeps;
        chMask = 8'h05;
        pulseTrig();
        waitSweeps(base + 1, 2000, "t1");
        applyStimulus(4);
        checkOutput("t1_wrt_count", wrtLog.size(), 4);
        for (int i = 0; i < 4 && i < wrtLog.size(); i++) checkOutput("t1_cmd", wrtLog[i], t1Cmds[i]);
        checkOutput("t1_res_vld", resVld, 8'h05);
        checkOutput("t1_model_vld", vldM, 8'h05);
        checkOutput("t1_sweeps", sweeps - base, 1);
        randRd = 1'b0;
        applyStimulus(1);
        rdCh = 3'd0;
        @(negedge clk);
        checkOutput("t1_rd_res_ch0", rdRes, resM[0]);
        applyStimulus(1);
        rdCh = 3'd2;
        @(negedge clk);
        checkOutput("t1_rd_res_ch2", rdRes, resM[2]);
        randRd = 1'b1;

        // Empty mask: no SPI traffic, sweep_done two cycles after trig.
        wrtLog.delete();
        base   = sweeps;
        chMask = 8'h00;
        pulseTrig();
        waitSweeps(base + 1, 50, "t2");
        applyStimulus(3);
        if (doneCycles.size() > 0) checkOutput("t2_done_latency", doneCycles[$] - trigCycle, 2);
        checkOutput("t2_wrt_count", wrtLog.size(), 0);
        checkOutput("t2_res_vld", resVld, 8'h05);

        // Trigs during a busy sweep collapse into one extra sweep using the new mask.
        latLo = 8;
        latHi = 12;
        wrtLog.delete();
        base   = sweeps;
        sb     = startCycles.size();
        db     = doneCycles.size();
        chMask = 8'h03;
        pulseTrig();
        applyStimulus(8);
        chMask = 8'h10;
        pulseTrig();
        applyStimulus(5);
        pulseTrig();
        waitSweeps(base + 2, 3000, "t5");
        waitIdle(500, "t5");
        checkOutput("t5_sweeps", sweeps - base, 2);
        checkOutput("t5_wrt_count", wrtLog.size(), 6);
        for (int i = 0; i < 6 && i < wrtLog.size(); i++) checkOutput("t5_cmd", wrtLog[i], t5Cmds[i]);
        if (startCycles.size() > sb + 1 && doneCycles.size() > db)
            checkOutput("t5_restart_gap", startCycles[sb + 1] - doneCycles[db], 2);
        checkOutput("t5_overrun", overrun, 1'b0);

        // Periodic sweeps of channel 0 every PERIOD clocks.
        latLo  = 2;
        latHi  = 8;
        chMask = 8'h01;
        base   = sweeps;
        sb     = startCycles.size();
        applyStimulus(1);
        en = 1'b1;
        applyStimulus(PERIOD * 3 + 20);
        en = 1'b0;
        waitIdle(400, "t3");
        checkOutput("t3_sweeps", sweeps - base, 3);
        checkOutput("t3_starts", startCycles.size() - sb, 3);
        for (int i = 1; i < 3 && sb + i < startCycles.size(); i++)
            checkOutput("t3_period", startCycles[sb + i] - startCycles[sb + i - 1], PERIOD);
        checkOutput("t3_overrun", overrun, 1'b0);

        // Long sweeps against a short period: back-to-back sweeps and a sticky overrun.
        latLo  = 25;
        latHi  = 35;
        chMask = 8'hFF;
        applyStimulus(1);
        en = 1'b1;
        applyStimulus(1100);
        en = 1'b0;
        waitIdle(3000, "t4");
        checkOutput("t4_overrun", overrun, 1'b1);

        // Random masks, trigs and periodic requests together.
        latLo = 2;
        latHi = 10;
        applyStimulus(1);
        en = 1'b1;
        for (int i = 0; i < 900; i++) begin
            trig = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) chMask = 8'($urandom);
            applyStimulus(1);
        end
        trig = 1'b0;
        en   = 1'b0;
        waitIdle(3000, "t7");

        // Reset while waiting for the first transaction.
        latLo  = 4;
        latHi  = 8;
        chMask = 8'h07;
        pulseTrig();
        n = 0;
        while (!wrt && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_saw_wrt", wrt, 1'b1);
        applyStimulus(1);
        rst_n = 1'b0;
        applyStimulus(1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_wrt", wrt, 1'b0);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_res_vld", resVld, 8'h00);
        checkOutput("t6_overrun", overrun, 1'b0);
        base = sweeps;
        pulseTrig();
        waitSweeps(base + 1, 2000, "t6");
        applyStimulus(3);
        checkOutput("t6_res_vld_after", resVld, 8'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
